// File: rtl/button_repeat_debouncer.sv
// rtl/button_repeat_debouncer.sv - push-button synchronizer, debouncer and hold-to-repeat step generator
`default_nettype none

module button_repeat_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic switch_input,
    output logic pressed,
    output logic trans_up,
    output logic trans_dn,
    output logic step,
    output logic repeating
);

    localparam longint unsigned MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam longint unsigned MAX_TC  = ((MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD) - 1;
    localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

    // Build-time guards: counters must hold their terminal counts, and the pulse outputs
    // can only be guaranteed non-adjacent when every interval is at least two cycles.
    if (MAX_TC >= CNT_LIM) begin : g_cnt_w_check
        $error("CNT_W too small for the configured cycle counts");
    end
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_interval_check
        $error("DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must each be at least 2");
    end

    localparam logic [CNT_W-1:0] DB_TC    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_TC   = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic             sync1_q, sync1_d;
    logic             s_in_q, s_in_d;
    logic             pressed_q, pressed_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             trans_up_q, trans_up_d;
    logic             trans_dn_q, trans_dn_d;
    logic             step_q, step_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;

    logic accept;
    logic rise;
    logic fall;

    always_comb begin
        sync1_d = switch_input;
        s_in_d  = sync1_q;
    end

    always_comb begin
        db_cnt_d  = '0;
        pressed_d = pressed_q;
        accept    = 1'b0;
        if (s_in_q != pressed_q) begin
            if (db_cnt_q == DB_TC) begin
                pressed_d = ~pressed_q;
                accept    = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        rise       = accept & ~pressed_q;
        fall       = accept & pressed_q;
        trans_up_d = rise;
        trans_dn_d = fall;
    end

    // Release is checked ahead of the state decode so it overrides a coincident repeat tick.
    always_comb begin
        state_d  = state_q;
        rp_cnt_d = rp_cnt_q;
        step_d   = 1'b0;
        if (fall) begin
            state_d  = ST_IDLE;
            rp_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rp_cnt_d = '0;
                    if (rise) begin
                        state_d = ST_DELAY;
                        step_d  = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (rp_cnt_q == DELAY_TC) begin
                        state_d  = ST_REPEAT;
                        step_d   = 1'b1;
                        rp_cnt_d = '0;
                    end else begin
                        rp_cnt_d = rp_cnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (rp_cnt_q == PER_TC) begin
                        step_d   = 1'b1;
                        rp_cnt_d = '0;
                    end else begin
                        rp_cnt_d = rp_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    rp_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q    <= 1'b0;
            s_in_q     <= 1'b0;
            pressed_q  <= 1'b0;
            db_cnt_q   <= '0;
            trans_up_q <= 1'b0;
            trans_dn_q <= 1'b0;
            step_q     <= 1'b0;
            state_q    <= ST_IDLE;
            rp_cnt_q   <= '0;
        end else begin
            sync1_q    <= sync1_d;
            s_in_q     <= s_in_d;
            pressed_q  <= pressed_d;
            db_cnt_q   <= db_cnt_d;
            trans_up_q <= trans_up_d;
            trans_dn_q <= trans_dn_d;
            step_q     <= step_d;
            state_q    <= state_d;
            rp_cnt_q   <= rp_cnt_d;
        end
    end

    assign pressed   = pressed_q;
    assign trans_up  = trans_up_q;
    assign trans_dn  = trans_dn_q;
    assign step      = step_q;
    assign repeating = (state_q == ST_REPEAT);

endmodule

`default_nettype wire

// File: tb/tb_button_repeat_debouncer.sv
// tb/tb_button_repeat_debouncer.sv - directed table and sequence checks for button_repeat_debouncer
`timescale 1ns/1ps

module tb_button_repeat_debouncer;

    localparam int unsigned DB  = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;
    localparam int unsigned CW  = 8;

    logic CLK;
    logic RST_N;
    logic switch_input;
    logic pressed;
    logic trans_up;
    logic trans_dn;
    logic step;
    logic repeating;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic pin;
        logic p;
        logic tu;
        logic td;
        logic st;
        logic rp;
    } vec_t;

    vec_t tbl[$];

    button_repeat_debouncer #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (CW)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .switch_input(switch_input),
        .pressed     (pressed),
        .trans_up    (trans_up),
        .trans_dn    (trans_dn),
        .step        (step),
        .repeating   (repeating)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic p, input logic tu,
                             input logic td, input logic st, input logic rp);
        check({tag, ".pressed"},   pressed,   p);
        check({tag, ".trans_up"},  trans_up,  tu);
        check({tag, ".trans_dn"},  trans_dn,  td);
        check({tag, ".step"},      step,      st);
        check({tag, ".repeating"}, repeating, rp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic void add(input logic pin, input logic p, input logic tu,
                                input logic td, input logic st, input logic rp);
        vec_t v;
        v.pin = pin; v.p = p; v.tu = tu; v.td = td; v.st = st; v.rp = rp;
        tbl.push_back(v);
    endfunction

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Clean press: accepted after the 6th edge, released 8 cycles in, falls 6 edges later.
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 1, 0);
        for (int i = 6; i < 8; i++) add(1, 1, 0, 0, 0, 0);
        for (int i = 8; i < 13; i++) add(0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        for (int i = 14; i < 20; i++) add(0, 0, 0, 0, 0, 0);
        // Bounce: pulses of 2 cycles never reach the 4-cycle acceptance window.
        add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0);

        // Async reset asserted between edges with the pin high.
        RST_N        = 1'b1;
        switch_input = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        check_all("reset_async", 0, 0, 0, 0, 0);
        tick();
        tick();
        check_all("reset_held", 0, 0, 0, 0, 0);
        switch_input = 1'b0;
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_all("idle_after_reset", 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            switch_input = tbl[i].pin;
            tick();
            check_all($sformatf("tbl[%0d]", i), tbl[i].p, tbl[i].tu, tbl[i].td, tbl[i].st, tbl[i].rp);
        end

        // Hold 40 cycles: steps at 6, 16, 19, ...; release lands on the tick at edge 46.
        for (int c = 1; c <= 50; c++) begin
            logic ep, et, ert;
            switch_input = (c <= 40);
            tick();
            ep  = (c >= 6) && (c < 46);
            ert = (c >= 16) && (c < 46);
            et  = ep && ((c == 6) || ((c >= 16) && (((c - 16) % 3) == 0)));
            check_all($sformatf("hold[%0d]", c), ep, (c == 6), (c == 46), et, ert);
            if (c == 46) check("release_vs_tick.step", step, 1'b0);
            if (c == 47) check("release_next.repeating", repeating, 1'b0);
        end
        for (int i = 0; i < 4; i++) tick();

        // Reset while repeating, pin still held: one fresh press after reset release.
        for (int c = 1; c <= 22; c++) begin
            switch_input = 1'b1;
            tick();
        end
        check("pre_reset.repeating", repeating, 1'b1);
        check("pre_reset.pressed", pressed, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        check_all("reset_mid_hold", 0, 0, 0, 0, 0);
        tick();
        tick();
        check_all("reset_mid_hold_held", 0, 0, 0, 0, 0);
        RST_N = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check_all($sformatf("reaccept[%0d]", c), (c >= 6), (c == 6), 1'b0, (c == 6), 1'b0);
        end

        switch_input = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_all("final_idle", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
